// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM counter configuration path.
package pwm_pkg;

    localparam int PERIOD_W     = 16;
    localparam int PRESCALE_W   = 8;
    localparam int PRESCALE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    // One complete counter configuration as held in the shadow registers.
    typedef struct packed {
        logic [PERIOD_W-1:0]   period;
        logic [PRESCALE_W-1:0] prescale;
        logic                  upnotdown;
        logic                  en;
        logic                  immediate;
    } cfg_t;

endpackage

// File: rtl/counter_cfg_sched_wrap_detect.sv
// Detects the counter's wrap boundary: the first cycle count_val lands on
// its start value. Start comes from the active (not shadow) settings.
module wrap_detect #(
    parameter int PERIOD_W = pwm_pkg::PERIOD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] count_val,
    input  logic [PERIOD_W-1:0] period,
    input  logic                upnotdown,
    output logic                boundary
);

    logic [PERIOD_W-1:0] prev_cnt;
    logic [PERIOD_W-1:0] start;

    // Start value depends on direction: up counters restart at 0, down at period-1.
    always_comb begin
        start = upnotdown ? '0 : (period - PERIOD_W'(1));
    end

    // Remember last cycle's count so a held value is not mistaken for a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_cnt <= '0;
        end else begin
            prev_cnt <= count_val;
        end
    end

    assign boundary = (count_val != prev_cnt) && (count_val == start);

endmodule

// File: rtl/counter_cfg_sched.sv
// Configuration scheduler: shadows new counter settings and commits them at
// the counter's wrap boundary (or at once when idle/immediate), pulsing
// count_reset so the counter restarts cleanly. Parameters must match pwm_pkg.
module counter_cfg_sched #(
    parameter int PERIOD_W     = pwm_pkg::PERIOD_W,
    parameter int PRESCALE_W   = pwm_pkg::PRESCALE_W,
    parameter int PRESCALE_MAX = pwm_pkg::PRESCALE_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_upnotdown,
    input  logic                  cfg_en,
    input  logic                  cfg_immediate,
    output logic                  cfg_err,
    output logic                  busy,
    output logic                  commit,
    input  logic [PERIOD_W-1:0]   count_val,
    output logic [PERIOD_W-1:0]   period,
    output logic [PRESCALE_W-1:0] prescale,
    output logic                  upnotdown,
    output logic                  en,
    output logic                  count_reset
);

    import pwm_pkg::*;

    localparam logic [PRESCALE_W-1:0] PRESCALE_CAP = PRESCALE_W'(PRESCALE_MAX);

    state_t                state;
    state_t                next_state;
    cfg_t                  shadow;
    logic                  boundary;
    logic                  commit_cond;
    logic                  load_shadow;
    logic                  load_active;
    logic                  reject;
    logic [PRESCALE_W-1:0] prescale_clamped;

    wrap_detect #(
        .PERIOD_W (PERIOD_W)
    ) u_wrap_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_val (count_val),
        .period    (period),
        .upnotdown (upnotdown),
        .boundary  (boundary)
    );

    assign commit_cond = shadow.immediate || !en || boundary;

    // Oversized prescale requests are silently limited to what the counter supports.
    always_comb begin
        prescale_clamped = (shadow.prescale > PRESCALE_CAP) ? PRESCALE_CAP : shadow.prescale;
    end

    // Next-state and handshake/commit strobes for the scheduler FSM.
    always_comb begin
        next_state  = state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        commit      = 1'b0;
        count_reset = 1'b0;
        load_shadow = 1'b0;
        load_active = 1'b0;
        reject      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_period != '0) begin
                        load_shadow = 1'b1;
                        next_state  = PENDING;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (commit_cond) begin
                    load_active = 1'b1;
                    next_state  = COMMIT;
                end
            end
            COMMIT: begin
                busy        = 1'b1;
                commit      = 1'b1;
                count_reset = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus the one-cycle rejection pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
        end else begin
            state   <= next_state;
            cfg_err <= reject;
        end
    end

    // Shadow captures an accepted request; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load_shadow) begin
            shadow.period    <= cfg_period;
            shadow.prescale  <= cfg_prescale;
            shadow.upnotdown <= cfg_upnotdown;
            shadow.en        <= cfg_en;
            shadow.immediate <= cfg_immediate;
        end
    end

    // Active settings only ever change on the PENDING-to-COMMIT transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period    <= '1;
            prescale  <= '0;
            upnotdown <= 1'b1;
            en        <= 1'b0;
        end else if (load_active) begin
            period    <= shadow.period;
            prescale  <= prescale_clamped;
            upnotdown <= shadow.upnotdown;
            en        <= shadow.en;
        end
    end

endmodule

// File: tb/tb_counter_cfg_sched.sv
// Directed bench for counter_cfg_sched with a simple behavioural counter
// closing the loop on count_val.
module tb_counter_cfg_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_prescale;
    logic        cfg_upnotdown;
    logic        cfg_en;
    logic        cfg_immediate;
    logic        cfg_err;
    logic        busy;
    logic        commit;
    logic [15:0] count_val = 16'd0;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic        upnotdown;
    logic        en;
    logic        count_reset;
    logic        cnt_hold;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  prescale;
        logic        up;
        logic        en;
        logic        imm;
        logic        exp_err;
        logic [15:0] exp_period;
        logic [7:0]  exp_prescale;
        logic        exp_up;
        logic        exp_en;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    counter_cfg_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_prescale  (cfg_prescale),
        .cfg_upnotdown (cfg_upnotdown),
        .cfg_en        (cfg_en),
        .cfg_immediate (cfg_immediate),
        .cfg_err       (cfg_err),
        .busy          (busy),
        .commit        (commit),
        .count_val     (count_val),
        .period        (period),
        .prescale      (prescale),
        .upnotdown     (upnotdown),
        .en            (en),
        .count_reset   (count_reset)
    );

    // Behavioural PWM counter: reloads on count_reset, otherwise steps when enabled.
    always @(posedge clk) begin
        if (!rst_n) begin
            count_val <= 16'd0;
        end else if (cnt_hold) begin
            count_val <= count_val;
        end else if (count_reset) begin
            count_val <= upnotdown ? 16'd0 : period - 16'd1;
        end else if (en) begin
            if (upnotdown) begin
                count_val <= (count_val >= period - 16'd1) ? 16'd0 : count_val + 16'd1;
            end else begin
                count_val <= (count_val == 16'd0 || count_val >= period) ? period - 16'd1 : count_val - 16'd1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_active(input string tag, input logic [15:0] p, input logic [7:0] ps,
                                input logic up, input logic e);
        check_output({tag, "_period"}, 32'(period), 32'(p));
        check_output({tag, "_prescale"}, 32'(prescale), 32'(ps));
        check_output({tag, "_up"}, 32'(upnotdown), 32'(up));
        check_output({tag, "_en"}, 32'(en), 32'(e));
    endtask

    task automatic check_reset_values(input string tag);
        check_active(tag, 16'hFFFF, 8'd0, 1'b1, 1'b0);
        check_output({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_commit"}, 32'(commit), 32'd0);
        check_output({tag, "_cntrst"}, 32'(count_reset), 32'd0);
        check_output({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    // Offers one configuration for a single cycle; returns at the negedge after the handshake edge.
    task automatic apply_stimulus(input logic [15:0] p, input logic [7:0] ps, input logic up,
                                  input logic e, input logic imm);
        @(negedge clk);
        cfg_period    = p;
        cfg_prescale  = ps;
        cfg_upnotdown = up;
        cfg_en        = e;
        cfg_immediate = imm;
        cfg_valid     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_count(input string tag, input logic [15:0] value);
        for (int k = 0; k < 40 && count_val != value; k++) @(negedge clk);
        check_output({tag, "_sync"}, 32'(count_val), 32'(value));
    endtask

    // Waits for the commit pulse, reporting the count values of the two cycles before it.
    task automatic wait_commit(input string tag, output logic [15:0] h1, output logic [15:0] h2);
        logic found;
        found = 1'b0;
        h1    = 16'hDEAD;
        h2    = 16'hDEAD;
        for (int k = 0; k < 40; k++) begin
            if (commit) begin
                found = 1'b1;
                break;
            end
            h2 = h1;
            h1 = count_val;
            @(negedge clk);
        end
        check_output({tag, "_commit_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] h1;
        logic [15:0] h2;
        logic        stall_ok;
        logic        no_commit;

        vecs[0] = '{16'd10,    8'd3,   1'b1, 1'b0, 1'b1, 1'b0, 16'd10,    8'd3,  1'b1, 1'b0};
        vecs[1] = '{16'd0,     8'd5,   1'b0, 1'b1, 1'b1, 1'b1, 16'd10,    8'd3,  1'b1, 1'b0};
        vecs[2] = '{16'd20,    8'd20,  1'b0, 1'b1, 1'b1, 1'b0, 16'd20,    8'd15, 1'b0, 1'b1};
        vecs[3] = '{16'd7,     8'd20,  1'b1, 1'b1, 1'b1, 1'b0, 16'd7,     8'd15, 1'b1, 1'b1};
        vecs[4] = '{16'd0,     8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 16'd7,     8'd15, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF,  8'd16,  1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF,  8'd15, 1'b0, 1'b0};
        vecs[6] = '{16'd1,     8'd15,  1'b1, 1'b1, 1'b1, 1'b0, 16'd1,     8'd15, 1'b1, 1'b1};
        vecs[7] = '{16'd300,   8'd14,  1'b1, 1'b0, 1'b1, 1'b0, 16'd300,   8'd14, 1'b1, 1'b0};

        rst_n         = 1'b0;
        cnt_hold      = 1'b0;
        cfg_valid     = 1'b0;
        cfg_period    = 16'd0;
        cfg_prescale  = 8'd0;
        cfg_upnotdown = 1'b0;
        cfg_en        = 1'b0;
        cfg_immediate = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Counter disabled: commit two cycles after the handshake.
        apply_stimulus(16'd10, 8'd0, 1'b1, 1'b1, 1'b0);
        check_output("s1_busy", 32'(busy), 32'd1);
        check_output("s1_ready", 32'(cfg_ready), 32'd0);
        check_output("s1_early_commit", 32'(commit), 32'd0);
        check_output("s1_en_old", 32'(en), 32'd0);
        @(negedge clk);
        check_output("s1_commit", 32'(commit), 32'd1);
        check_output("s1_cntrst", 32'(count_reset), 32'd1);
        check_active("s1", 16'd10, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        check_output("s1_cntrst_off", 32'(count_reset), 32'd0);
        check_output("s1_ready_back", 32'(cfg_ready), 32'd1);
        check_output("s1_busy_off", 32'(busy), 32'd0);

        // Running up with period 10: new period waits for the 9->0 wrap.
        wait_count("s2", 16'd3);
        apply_stimulus(16'd4, 8'd0, 1'b1, 1'b1, 1'b0);
        wait_commit("s2", h1, h2);
        check_output("s2_wrap_val", 32'(h1), 32'd0);
        check_output("s2_before_wrap", 32'(h2), 32'd9);
        check_output("s2_period", 32'(period), 32'd4);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check_output($sformatf("s2_cnt%0d", j), 32'(count_val), 32'(j % 4));
        end

        // Switch to counting down with period 8, then request up; commit waits for the step to 7.
        apply_stimulus(16'd8, 8'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_output("s3_imm_commit", 32'(commit), 32'd1);
        wait_count("s3", 16'd4);
        apply_stimulus(16'd8, 8'd0, 1'b1, 1'b1, 1'b0);
        check_output("s3_dir_held", 32'(upnotdown), 32'd0);
        wait_commit("s3", h1, h2);
        check_output("s3_wrap_val", 32'(h1), 32'd7);
        check_output("s3_before_wrap", 32'(h2), 32'd0);
        check_output("s3_up", 32'(upnotdown), 32'd1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_output($sformatf("s3_cnt%0d", j), 32'(count_val), 32'(j));
        end

        // Table of single writes, each immediate or rejected.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].period, vecs[i].prescale, vecs[i].up, vecs[i].en, vecs[i].imm);
            check_output($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            check_output($sformatf("v%0d_busy", i), 32'(busy), 32'(!vecs[i].exp_err));
            check_output($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_err));
            @(negedge clk);
            check_output($sformatf("v%0d_commit", i), 32'(commit), 32'(!vecs[i].exp_err));
            check_output($sformatf("v%0d_cntrst", i), 32'(count_reset), 32'(!vecs[i].exp_err));
            check_output($sformatf("v%0d_err_off", i), 32'(cfg_err), 32'd0);
            check_active($sformatf("v%0d", i), vecs[i].exp_period, vecs[i].exp_prescale,
                         vecs[i].exp_up, vecs[i].exp_en);
            @(negedge clk);
            check_output($sformatf("v%0d_ready_after", i), 32'(cfg_ready), 32'd1);
            check_output($sformatf("v%0d_commit_off", i), 32'(commit), 32'd0);
        end

        // Stalled counter keeps the request pending; reset then discards it.
        apply_stimulus(16'd5, 8'd2, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        cnt_hold = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(16'd9, 8'd1, 1'b0, 1'b1, 1'b0);
        stall_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!busy || commit) stall_ok = 1'b0;
            @(negedge clk);
        end
        check_output("s4_stall_pending", 32'(stall_ok), 32'd1);
        check_active("s4_held", 16'd5, 8'd2, 1'b1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("s4_rst");
        rst_n = 1'b1;
        no_commit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (commit || busy) no_commit = 1'b0;
        end
        check_output("s4_no_commit", 32'(no_commit), 32'd1);
        check_active("s4_after", 16'hFFFF, 8'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_cfg_sched.md
# counter_cfg_sched

Configuration scheduler for the PWM counter. Accepts new counter settings (period, prescale, direction, enable) over a valid/ready port and holds them in shadow registers. It commits them glitch-free at the counter's wrap boundary, pulsing `count_reset` so the counter restarts cleanly from its start value. It sits between the register file and the counter.

## Interface
Parameters:
- PERIOD_W, 16, width of period and count_val
- PRESCALE_W, 8, width of prescale field
- PRESCALE_MAX, 15, largest prescale exponent passed to the counter

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset, active-low, synchronous to clk
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  scheduler can accept a configuration
- cfg_period  in  PERIOD_W  requested period, 0 is illegal
- cfg_prescale  in  PRESCALE_W  requested prescale exponent
- cfg_upnotdown  in  1  requested direction, 1 means up
- cfg_en  in  1  requested counter enable
- cfg_immediate  in  1  commit without waiting for the boundary
- cfg_err  out  1  one-cycle pulse when a configuration is rejected
- busy  out  1  a configuration is pending or committing
- commit  out  1  one-cycle pulse in the cycle new settings go live
- count_val  in  PERIOD_W  current counter value, read from the counter
- period  out  PERIOD_W  active period, to the counter
- prescale  out  PRESCALE_W  active prescale, to the counter
- upnotdown  out  1  active direction, to the counter
- en  out  1  active enable, to the counter
- count_reset  out  1  restart pulse, to the counter

## Operation
- Reset values: period=16'hFFFF, prescale=0, upnotdown=1, en=0, count_reset=0, cfg_ready=1, cfg_err=0, busy=0, commit=0, state=IDLE, prev_cnt=0.
- The state machine has three states: IDLE, PENDING and COMMIT.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with cfg_period!=0: latch all cfg_* fields into the shadow registers, then go to PENDING.
  - On cfg_valid with cfg_period==0: pulse cfg_err the next cycle, leave the shadow unchanged and stay in IDLE. The handshake still completes.
- PENDING:
  - cfg_ready=0 and busy=1.
  - Commit condition: shadow immediate bit set, OR active en==0, OR boundary.
  - When the condition holds, load the active output registers from the shadow, set count_reset=1 and commit=1, then go to COMMIT.
- COMMIT:
  - count_reset, commit and busy are all 1. This lasts exactly one cycle, then go to IDLE.
- Boundary: `(count_val != prev_cnt) && (count_val == start)`.
  - start is 0 when active upnotdown=1.
  - start is active period-1 when active upnotdown=0.
  - prev_cnt is a register that samples count_val every cycle.
- Prescale clamp: a shadow prescale greater than PRESCALE_MAX is driven as PRESCALE_MAX. No error is raised.
- Direction changes and period changes only ever take effect through COMMIT. Active outputs never change outside the COMMIT load.

## Timing
- Handshake at edge T (IDLE, cfg_valid=1) means state is PENDING in cycle T+1.
- Commit condition true in cycle C means the COMMIT cycle is C+1. New outputs and count_reset=1 appear in cycle C+1, and the counter reloads at the end of C+1.
- Latency with en=0 or cfg_immediate: the handshake to the commit pulse is 2 cycles.
- cfg_ready is back to 1 in the cycle after COMMIT.
- Back-to-back writes are possible at most once every 3 cycles.
- Boundary evaluation uses the active (old) period and direction, never the shadow values.
- rst_n low mid-operation: on the next edge all state and outputs take their reset values and any pending shadow is discarded.
- Stalled counter: with en=1 and a value that never changes, the scheduler stays in PENDING indefinitely. This is by design; software uses cfg_immediate to escape.

## Structure
- Shared package pwm_pkg holds:
  - the state enum {IDLE, PENDING, COMMIT};
  - the PERIOD_W, PRESCALE_W and PRESCALE_MAX constants;
  - a packed cfg struct with fields period, prescale, upnotdown, en and immediate.
- One natural sub-module, wrap_detect. It owns prev_cnt, takes count_val, active period and active upnotdown as inputs, and outputs the single-cycle boundary signal.
- The FSM, the shadow registers and the active registers stay in the top level.

## Test plan
- After reset, write period=10, prescale=0, up=1, en=1 with the counter idle (en=0 path) → commit pulse 2 cycles after the handshake; period=10 and en=1 are live; count_reset is high for 1 cycle; cfg_ready returns.
- While running up with period=10, write period=4 → stays PENDING until count_val steps from 9 to 0, commits one cycle later, and afterwards count_val cycles 0..3.
- While running down with period=8, write up=1 → the commit follows count_val stepping to 7; afterwards the counter counts 0,1,2,… upward.
- Write with cfg_period=0 → cfg_err pulses for 1 cycle; period, prescale and state are unchanged; cfg_ready stays 1.
- Write with cfg_prescale=20 and cfg_immediate=1 while running → prescale=15 is driven; commit occurs 2 cycles after the handshake without waiting for a boundary.
- Assert rst_n=0 for 1 cycle while in PENDING → all outputs are at reset values on the next cycle and no commit pulse ever appears.
